// File: rtl/retire_store_buffer.sv
// Post-retire store FIFO: up to WAYS stores in per cycle, one drained per accepted Dmem cycle; STORE_FWD_EN enables load forwarding.
// Enqueued entries are visible to memory one cycle later; loads (load_busy) and a zero response both hold the head store.
module retire_store_buffer #(
    parameter int WAYS  = 3,
    parameter int DEPTH = 8,
    parameter int XLEN  = 32
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic [WAYS-1:0]          st_valid,
    input  logic [WAYS*XLEN-1:0]     st_addr,
    input  logic [WAYS*XLEN-1:0]     st_data,
    input  logic [WAYS*2-1:0]        st_size,
    output logic [$clog2(DEPTH):0]   free_slots,
    input  logic                     load_busy,
    input  logic [3:0]               Dmem2proc_response,
    output logic [1:0]               proc2Dmem_command,
    output logic [XLEN-1:0]          proc2Dmem_addr,
    output logic [XLEN-1:0]          proc2Dmem_data,
    output logic [1:0]               proc2Dmem_size,
    input  logic                     halt_req,
    output logic                     drained,
    output logic                     overflow,
    input  logic [XLEN-1:0]          ld_addr,
    output logic                     ld_fwd_hit,
    output logic [XLEN-1:0]          ld_fwd_data,
    output logic                     ld_fwd_conflict
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;
    localparam logic [1:0] BUS_NONE  = 2'h0;
    localparam logic [1:0] BUS_STORE = 2'h2;
    localparam logic [1:0] SZ_WORD   = 2'h2;

    typedef enum logic [1:0] {IDLE, DRAIN, STALL} state_t;

    state_t          state, state_next, bus_state;
    logic [PW-1:0]   head, tail;
    logic [CW-1:0]   count, count_next, space, n_written;
    logic            pop, ovf_now, halt_lat;
    logic [WAYS-1:0] wr_en;
    logic [PW-1:0]   wr_slot [WAYS];

    logic [XLEN-1:0] mem_addr [DEPTH];
    logic [XLEN-1:0] mem_data [DEPTH];
    logic [1:0]      mem_size [DEPTH];

    // The registered state only knows whether entries exist; the bus is yielded
    // combinationally so a load this cycle never collides with a store.
    always_comb begin
        bus_state         = IDLE;
        proc2Dmem_command = BUS_NONE;
        if (state != IDLE) begin
            if (load_busy) begin
                bus_state = STALL;
            end else begin
                bus_state         = DRAIN;
                proc2Dmem_command = BUS_STORE;
            end
        end
    end

    assign proc2Dmem_addr = mem_addr[head];
    assign proc2Dmem_data = mem_data[head];
    assign proc2Dmem_size = mem_size[head];
    assign free_slots     = CW'(DEPTH) - count;

    // Valid lanes are packed densely from tail; lanes beyond the room left are dropped.
    always_comb begin
        logic [CW-1:0] k;
        pop     = (bus_state == DRAIN) && (Dmem2proc_response != 4'h0);
        space   = CW'(DEPTH) - count + CW'(pop);
        ovf_now = 1'b0;
        k       = '0;
        for (int i = 0; i < WAYS; i++) begin
            wr_en[i]   = 1'b0;
            wr_slot[i] = tail + k[PW-1:0];
            if (st_valid[i]) begin
                if (k < space) begin
                    wr_en[i] = 1'b1;
                    k        = k + CW'(1);
                end else begin
                    ovf_now = 1'b1;
                end
            end
        end
        n_written  = k;
        count_next = count + n_written - CW'(pop);
    end

    always_comb begin
        state_next = IDLE;
        if (count_next != '0) begin
            state_next = load_busy ? STALL : DRAIN;
        end
    end

    always_ff @(posedge clock) begin
        if (reset) begin
            head     <= '0;
            tail     <= '0;
            count    <= '0;
            state    <= IDLE;
            halt_lat <= 1'b0;
            drained  <= 1'b0;
            overflow <= 1'b0;
        end else begin
            if (pop) begin
                head <= head + PW'(1);
            end
            tail     <= tail + n_written[PW-1:0];
            count    <= count_next;
            state    <= state_next;
            halt_lat <= halt_lat | halt_req;
            drained  <= (halt_lat | halt_req) && (count_next == '0);
            if (ovf_now) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clock) begin
        for (int i = 0; i < WAYS; i++) begin
            if (wr_en[i]) begin
                mem_addr[wr_slot[i]] <= st_addr[i*XLEN +: XLEN];
                mem_data[wr_slot[i]] <= st_data[i*XLEN +: XLEN];
                mem_size[wr_slot[i]] <= st_size[i*2 +: 2];
            end
        end
    end

    // Walk oldest to youngest so the last match found is the youngest store.
    logic            fwd_match;
`ifdef STORE_FWD_EN
    logic            fwd_word;
    logic [XLEN-1:0] fwd_dat;
`endif
    always_comb begin
        logic [PW-1:0] slot;
        fwd_match = 1'b0;
`ifdef STORE_FWD_EN
        fwd_word  = 1'b0;
        fwd_dat   = '0;
`endif
        for (int o = 0; o < DEPTH; o++) begin
            slot = head + PW'(o);
            if ((CW'(o) < count) && (mem_addr[slot][XLEN-1:2] == ld_addr[XLEN-1:2])) begin
                fwd_match = 1'b1;
`ifdef STORE_FWD_EN
                fwd_word  = (mem_size[slot] == SZ_WORD);
                fwd_dat   = mem_data[slot];
`endif
            end
        end
    end

`ifdef STORE_FWD_EN
    assign ld_fwd_hit      = fwd_match & fwd_word;
    assign ld_fwd_data     = ld_fwd_hit ? fwd_dat : '0;
    assign ld_fwd_conflict = fwd_match & ~fwd_word;
`else
    assign ld_fwd_hit      = 1'b0;
    assign ld_fwd_data     = '0;
    assign ld_fwd_conflict = fwd_match;
`endif

    logic unused_ld_lsb;
    assign unused_ld_lsb = ^ld_addr[1:0];

endmodule
